// File: rtl/odo_round_key_seq.sv
// odo_round_key_seq: writable round-key table for the Odo hashing core.
// The table resets to DEFAULT_KEYS and can be rewritten at runtime.
// It feeds two consumers: a one-cycle lookup port and a valid/ready key
// sequencer that wraps from the last period back to period 0.
//
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   wr_en/addr/data  table write (out-of-range address ignored)
//   lk_period        lookup index; lk_key/lk_err are registered results
//   seq_start/first/count  sequencer launch request (accepted in IDLE)
//   seq_valid/ready  stream handshake; seq_key/seq_period/seq_last payload
//   seq_busy         sequencer is running
module odo_round_key_seq #(
  parameter int unsigned KEY_W       = 10,
  parameter int unsigned NUM_PERIODS = 10,
  parameter int unsigned PERIOD_W    = 4,
  parameter int unsigned CNT_W       = 8,
  parameter logic [NUM_PERIODS*KEY_W-1:0] DEFAULT_KEYS = {
    10'h1c6, 10'h1ce, 10'h073, 10'h091, 10'h335,
    10'h008, 10'h229, 10'h2d7, 10'h2d9, 10'h3ef
  }
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [PERIOD_W-1:0] wr_addr,
  input  logic [KEY_W-1:0]    wr_data,
  input  logic [PERIOD_W-1:0] lk_period,
  output logic [KEY_W-1:0]    lk_key,
  output logic                lk_err,
  input  logic                seq_start,
  input  logic [PERIOD_W-1:0] seq_first,
  input  logic [CNT_W-1:0]    seq_count,
  output logic                seq_busy,
  output logic                seq_valid,
  input  logic                seq_ready,
  output logic [KEY_W-1:0]    seq_key,
  output logic [PERIOD_W-1:0] seq_period,
  output logic                seq_last
);

  localparam int unsigned NP_W = PERIOD_W + 1;
  localparam logic [NP_W-1:0]     NP_LIM   = NP_W'(NUM_PERIODS);
  localparam logic [PERIOD_W-1:0] LAST_IDX = PERIOD_W'(NUM_PERIODS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [KEY_W-1:0] tbl_q [NUM_PERIODS];

  logic [0:0]          state_q, state_d;
  logic [PERIOD_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [KEY_W-1:0]    lk_key_q, lk_key_d;
  logic                lk_err_q, lk_err_d;
  logic                seq_valid_q, seq_valid_d;
  logic                seq_last_q, seq_last_d;
  logic [KEY_W-1:0]    seq_key_q, seq_key_d;
  logic [PERIOD_W-1:0] seq_period_q, seq_period_d;
  logic [PERIOD_W-1:0] ptr_nxt;
  logic                wr_hit;

  function automatic logic in_range(input logic [PERIOD_W-1:0] idx);
    return ({1'b0, idx} < NP_LIM);
  endfunction

  // Table read with same-cycle write bypass; caller guarantees idx in range.
  function automatic logic [KEY_W-1:0] rd_key(input logic [PERIOD_W-1:0] idx,
                                              input logic                hit,
                                              input logic [PERIOD_W-1:0] waddr,
                                              input logic [KEY_W-1:0]    wdata);
    logic [KEY_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_PERIODS; i++) begin
      if (idx == PERIOD_W'(i)) v = tbl_q[i];
    end
    if (hit && (waddr == idx)) v = wdata;
    return v;
  endfunction

  assign wr_hit  = wr_en && in_range(wr_addr);
  assign ptr_nxt = (ptr_q == LAST_IDX) ? '0 : ptr_q + PERIOD_W'(1);

  // Key table: reset to defaults, single write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PERIODS; i++) begin
        tbl_q[i] <= DEFAULT_KEYS[i*KEY_W +: KEY_W];
      end
    end else if (wr_hit) begin
      for (int unsigned i = 0; i < NUM_PERIODS; i++) begin
        if (wr_addr == PERIOD_W'(i)) tbl_q[i] <= wr_data;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      rem_q        <= '0;
      lk_key_q     <= '0;
      lk_err_q     <= 1'b0;
      seq_valid_q  <= 1'b0;
      seq_last_q   <= 1'b0;
      seq_key_q    <= '0;
      seq_period_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rem_q        <= rem_d;
      lk_key_q     <= lk_key_d;
      lk_err_q     <= lk_err_d;
      seq_valid_q  <= seq_valid_d;
      seq_last_q   <= seq_last_d;
      seq_key_q    <= seq_key_d;
      seq_period_q <= seq_period_d;
    end
  end

  // Lookup path and sequencer next-state logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rem_d        = rem_q;
    lk_key_d     = lk_key_q;
    lk_err_d     = 1'b1;
    seq_valid_d  = seq_valid_q;
    seq_last_d   = seq_last_q;
    seq_key_d    = seq_key_q;
    seq_period_d = seq_period_q;

    // Out-of-range lookups keep the last good key and raise lk_err.
    if (in_range(lk_period)) begin
      lk_key_d = rd_key(lk_period, wr_hit, wr_addr, wr_data);
      lk_err_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (seq_start && (seq_count != '0) && in_range(seq_first)) begin
          ptr_d        = seq_first;
          rem_d        = seq_count;
          seq_key_d    = rd_key(seq_first, wr_hit, wr_addr, wr_data);
          seq_period_d = seq_first;
          seq_valid_d  = 1'b1;
          seq_last_d   = (seq_count == CNT_W'(1));
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        // Stalled beats hold every output, so only an accept moves state.
        if (seq_valid_q && seq_ready) begin
          if (rem_q == CNT_W'(1)) begin
            seq_valid_d = 1'b0;
            seq_last_d  = 1'b0;
            state_d     = S_IDLE;
          end else begin
            ptr_d        = ptr_nxt;
            rem_d        = rem_q - CNT_W'(1);
            seq_key_d    = rd_key(ptr_nxt, wr_hit, wr_addr, wr_data);
            seq_period_d = ptr_nxt;
            seq_last_d   = (rem_q == CNT_W'(2));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign lk_key     = lk_key_q;
  assign lk_err     = lk_err_q;
  assign seq_busy   = (state_q == S_RUN);
  assign seq_valid  = seq_valid_q;
  assign seq_key    = seq_key_q;
  assign seq_period = seq_period_q;
  assign seq_last   = seq_last_q;

endmodule

// File: tb/tb_odo_round_key_seq.sv
// Self-checking bench for odo_round_key_seq: lookup sweep, write-through,
// reset restore, streaming with stalls, ignored starts and mid-run reset.
module tb_odo_round_key_seq;

  localparam int NP = 10;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [9:0] wr_data;
  logic [3:0] lk_period;
  logic [9:0] lk_key;
  logic       lk_err;
  logic       seq_start;
  logic [3:0] seq_first;
  logic [7:0] seq_count;
  logic       seq_busy;
  logic       seq_valid;
  logic       seq_ready;
  logic [9:0] seq_key;
  logic [3:0] seq_period;
  logic       seq_last;

  typedef struct {
    logic [3:0] period;
    logic [9:0] key;
    logic       last;
  } beat_t;

  beat_t      exp_q[$];
  logic [9:0] lk_q[$];
  logic [9:0] model [NP];
  localparam logic [9:0] DEF [NP] = '{10'h3ef, 10'h2d9, 10'h2d7, 10'h229, 10'h008,
                                      10'h335, 10'h091, 10'h073, 10'h1ce, 10'h1c6};

  int tests;
  int failed;

  odo_round_key_seq dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lk_period(lk_period), .lk_key(lk_key), .lk_err(lk_err),
    .seq_start(seq_start), .seq_first(seq_first), .seq_count(seq_count),
    .seq_busy(seq_busy), .seq_valid(seq_valid), .seq_ready(seq_ready),
    .seq_key(seq_key), .seq_period(seq_period), .seq_last(seq_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) model[i] = DEF[i];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    model_reset();
    tests++; if (lk_key !== 10'h000) begin failed++; $display("FAIL reset_lk_key got %h exp 000", lk_key); end
    tests++; if (lk_err !== 1'b0) begin failed++; $display("FAIL reset_lk_err got %b exp 0", lk_err); end
    tests++; if (seq_valid !== 1'b0) begin failed++; $display("FAIL reset_seq_valid got %b exp 0", seq_valid); end
    tests++; if (seq_busy !== 1'b0) begin failed++; $display("FAIL reset_seq_busy got %b exp 0", seq_busy); end
    tests++; if (seq_last !== 1'b0) begin failed++; $display("FAIL reset_seq_last got %b exp 0", seq_last); end
    tests++; if (seq_key !== 10'h000 || seq_period !== 4'd0) begin
      failed++; $display("FAIL reset_seq_payload got %h/%0d exp 000/0", seq_key, seq_period);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lookup_sweep();
    logic [9:0] e;
    for (int p = 0; p < NP; p++) begin
      lk_period = 4'(p);
      lk_q.push_back(model[p]);
      tick();
      e = lk_q.pop_front();
      tests++; if (lk_key !== e || lk_err !== 1'b0) begin
        failed++; $display("FAIL lookup_%0d got %h err %b exp %h err 0", p, lk_key, lk_err, e);
      end
    end
    lk_period = 4'd12;
    tick();
    tests++; if (lk_key !== 10'h1c6 || lk_err !== 1'b1) begin
      failed++; $display("FAIL lookup_oor got %h err %b exp 1c6 err 1", lk_key, lk_err);
    end
  endtask

  task automatic test_write_through();
    lk_period = 4'd4; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 10'h155;
    model[4] = 10'h155;
    tick();
    wr_en = 1'b0;
    tests++; if (lk_key !== 10'h155) begin failed++; $display("FAIL write_bypass got %h exp 155", lk_key); end
    // Out-of-range write must not disturb any entry.
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 10'h2aa;
    tick();
    wr_en = 1'b0;
    for (int p = 0; p < NP; p++) begin
      lk_period = 4'(p);
      tick();
      tests++; if (lk_key !== model[p]) begin
        failed++; $display("FAIL write_oor_entry_%0d got %h exp %h", p, lk_key, model[p]);
      end
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    lk_period = 4'd4;
    tick();
    tests++; if (lk_key !== 10'h008) begin failed++; $display("FAIL reset_restore got %h exp 008", lk_key); end
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating.
  // do_wr rewrites the held entry during the first stall.
  // poke re-asserts seq_start with other arguments while running.
  task automatic run_seq(input int first, input int count, input int mode,
                         input bit do_wr, input bit poke);
    bit    rdy;
    bit    wrote;
    int    cyc;
    beat_t b;
    wrote = 1'b0;
    for (int i = 0; i < count; i++) begin
      b.period = 4'((first + i) % NP);
      b.key    = model[(first + i) % NP];
      b.last   = (i == count - 1);
      exp_q.push_back(b);
    end
    seq_first = 4'(first); seq_count = 8'(count); seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    tests++; if (seq_valid !== 1'b1) begin failed++; $display("FAIL seq_first_valid got %b exp 1", seq_valid); end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      b = exp_q[0];
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      tests++;
      if (seq_valid !== 1'b1 || seq_busy !== 1'b1 || seq_period !== b.period ||
          seq_key !== b.key || seq_last !== b.last) begin
        failed++;
        $display("FAIL seq_beat got v%b b%b p%0d k%h l%b exp v1 b1 p%0d k%h l%b",
                 seq_valid, seq_busy, seq_period, seq_key, seq_last, b.period, b.key, b.last);
      end
      if (do_wr && !rdy && !wrote) begin
        wr_en = 1'b1; wr_addr = b.period; wr_data = ~b.key;
        model[b.period] = ~b.key;
        wrote = 1'b1;
      end
      if (poke && cyc == 0) begin
        seq_start = 1'b1; seq_first = 4'd5; seq_count = 8'd1;
      end
      seq_ready = rdy;
      tick();
      wr_en = 1'b0;
      seq_start = 1'b0;
      if (rdy) void'(exp_q.pop_front());
      cyc++;
    end
    tests++; if (exp_q.size() != 0) begin
      failed++; $display("FAIL seq_timeout got %0d beats left exp 0", exp_q.size());
      exp_q.delete();
    end
    tests++; if (seq_valid !== 1'b0 || seq_busy !== 1'b0) begin
      failed++; $display("FAIL seq_end got v%b b%b exp v0 b0", seq_valid, seq_busy);
    end
    seq_ready = 1'b0;
  endtask

  task automatic test_stream();
    run_seq(8, 4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    run_seq(8, 4, 1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_seq(3, 3, 0, 1'b0, 1'b0);
    run_seq(6, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored();
    seq_start = 1'b1; seq_first = 4'd2; seq_count = 8'd0;
    tick();
    tests++; if (seq_valid !== 1'b0 || seq_busy !== 1'b0) begin
      failed++; $display("FAIL ign_count0 got v%b b%b exp v0 b0", seq_valid, seq_busy);
    end
    seq_first = 4'd10; seq_count = 8'd3;
    tick();
    seq_start = 1'b0;
    tests++; if (seq_valid !== 1'b0 || seq_busy !== 1'b0) begin
      failed++; $display("FAIL ign_first_oor got v%b b%b exp v0 b0", seq_valid, seq_busy);
    end
    run_seq(0, 3, 1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    seq_first = 4'd2; seq_count = 8'd5; seq_start = 1'b1; seq_ready = 1'b1;
    tick();
    seq_start = 1'b0;
    tick();
    tests++; if (seq_valid !== 1'b1 || seq_period !== 4'd3 || seq_key !== model[3]) begin
      failed++; $display("FAIL midrun_beat2 got v%b p%0d k%h exp v1 p3 k%h",
                         seq_valid, seq_period, seq_key, model[3]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    tests++; if (seq_valid !== 1'b0 || seq_busy !== 1'b0) begin
      failed++; $display("FAIL midrun_reset got v%b b%b exp v0 b0", seq_valid, seq_busy);
    end
    tick();
    tests++; if (seq_valid !== 1'b0) begin
      failed++; $display("FAIL midrun_no_beats got v%b exp 0", seq_valid);
    end
    seq_ready = 1'b0;
    run_seq(9, 2, 0, 1'b0, 1'b0);
  endtask

  initial begin
    tests = 0; failed = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; lk_period = '0;
    seq_start = 1'b0; seq_first = '0; seq_count = '0; seq_ready = 1'b0;
    model_reset();
    test_reset();
    test_lookup_sweep();
    test_write_through();
    test_stream();
    test_stall();
    test_back_to_back();
    test_ignored();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/odo_round_key_seq.md
# odo_round_key_seq

Parametrised, writable round-key store with a direct lookup port and an autonomous key sequencer for the Odo hashing core. It replaces the fixed per-period constant tables with a register file that resets to a default table and can be rewritten at runtime. It serves two consumers:
- a single-cycle lookup for the round datapath;
- a valid/ready stream of consecutive round keys, with period wrap-around, for pipelined round units.

## Interface
Parameters:
- KEY_W, 10, key width in bits.
- NUM_PERIODS, 10, number of table entries (periods 0..NUM_PERIODS-1); range 2..16.
- PERIOD_W, 4, period index width; must satisfy 2^PERIOD_W >= NUM_PERIODS.
- CNT_W, 8, width of sequencer round count.
- DEFAULT_KEYS, NUM_PERIODS*KEY_W bits, reset table contents; entry i at bits [i*KEY_W +: KEY_W]. Default entries 0..9: 0x3ef, 0x2d9, 0x2d7, 0x229, 0x008, 0x335, 0x091, 0x073, 0x1ce, 0x1c6.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  table write strobe.
- wr_addr  in  PERIOD_W  entry to write.
- wr_data  in  KEY_W  new key value.
- lk_period  in  PERIOD_W  lookup index, sampled every cycle.
- lk_key  out  KEY_W  registered lookup result.
- lk_err  out  1  registered flag: previous-cycle lk_period was out of range.
- seq_start  in  1  start pulse for the sequencer.
- seq_first  in  PERIOD_W  first period of the sequence.
- seq_count  in  CNT_W  number of keys to emit.
- seq_busy  out  1  sequencer is not IDLE.
- seq_valid  out  1  seq_key/seq_period hold a beat.
- seq_ready  in  1  consumer accepts the beat.
- seq_key  out  KEY_W  streamed key.
- seq_period  out  PERIOD_W  period index of seq_key.
- seq_last  out  1  current beat is the final one.

## Operation
- Reset (rst_n=0 at a clk edge):
  - table <= DEFAULT_KEYS;
  - lk_key, lk_err, seq_key, seq_period, seq_valid, seq_last, seq_busy all 0;
  - FSM <= IDLE.
- Table write: when wr_en=1 and wr_addr<NUM_PERIODS, the entry updates at the clock edge. An out-of-range wr_addr is ignored.
- Write-through: any read (lookup or sequencer load) of the entry being written in the same cycle returns wr_data.
- Lookup:
  - In range: lk_key <= table[lk_period] and lk_err <= 0, every cycle.
  - Out of range: lk_key holds its value and lk_err <= 1.
- Sequencer FSM, states IDLE and RUN.
  - IDLE + seq_start=1, seq_count!=0, seq_first<NUM_PERIODS:
    - load ptr=seq_first, rem=seq_count;
    - seq_key <= table[seq_first], seq_period <= seq_first;
    - seq_valid <= 1, seq_last <= (seq_count==1), go to RUN.
  - IDLE + seq_start with seq_count=0 or seq_first out of range: ignored, remain IDLE.
  - RUN, seq_valid & seq_ready (accept):
    - if rem==1: seq_valid <= 0, seq_last <= 0, go to IDLE;
    - else: ptr <= (ptr==NUM_PERIODS-1) ? 0 : ptr+1 and rem <= rem-1;
    - seq_key/seq_period load the new ptr entry;
    - seq_last <= (rem==2).
  - RUN, seq_valid & !seq_ready: all seq_* outputs hold, including seq_key even if its table entry is written meanwhile.
- seq_start while RUN: ignored.
- seq_busy = (state==RUN).

## Timing
- Lookup latency: 1 cycle (lk_period at edge N appears on lk_key after edge N).
- Sequencer:
  - first seq_valid is asserted the cycle after seq_start is sampled;
  - steady-state throughput is 1 beat/cycle with seq_ready held high;
  - the next seq_start is accepted the cycle after the final accept (seq_busy low).
- Writes are visible to lookup/sequencer loads in the same cycle (bypass) and afterwards.
- Reset mid-RUN: seq_valid drops at that edge and no further beats are emitted. Table returns to defaults even if rewritten.

## Test plan
- Reset, then sweep lk_period 0..9 -> lk_key = 0x3ef, 0x2d9, 0x2d7, 0x229, 0x008, 0x335, 0x091, 0x073, 0x1ce, 0x1c6, each one cycle later; lk_period=12 -> lk_key holds 0x1c6, lk_err=1.
- Write 0x155 to entry 4 while lk_period=4 in the same cycle -> lk_key=0x155 next cycle. Assert rst_n=0 -> lookup of 4 returns 0x008.
- seq_first=8, seq_count=4, seq_ready=1 -> beats (8,0x1ce), (9,0x1c6), (0,0x3ef), (1,0x2d9) on consecutive cycles. seq_last is set on the 4th beat only; seq_busy drops after it.
- Same sequence with seq_ready toggling 1,0,0,1,... -> no beat lost or duplicated; outputs stable while stalled. A write to the held entry during a stall does not alter seq_key.
- seq_start with seq_count=0, with seq_first=10, and again while busy -> no seq_valid and no state change.
- rst_n=0 during beat 2 of a 5-beat run -> seq_valid=0 next cycle and FSM IDLE. A new seq_start after reset runs normally.
